transpose_stream_ctrl: RTL and testbench

TRANSPOSE_STREAM_CTRL -- requirements
Module: transpose_stream_ctrl

---
 rtl/transpose_stream_ctrl_pkg.sv | 18 +
 rtl/transpose_stream_ctrl.sv | 130 +++++++++++++
 tb/tb_transpose_stream_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/transpose_stream_ctrl_pkg.sv
// Shared definitions for the transpose stream controller: FSM encoding and
// block geometry.
package transpose_stream_ctrl_pkg;

    // Rows per transpose block; job lengths must be a whole number of blocks.
    localparam int BLOCK_ROWS = 64;

    // Width of one streamed row in bits.
    localparam int ROW_BITS = 512;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/transpose_stream_ctrl.sv
// Job controller for the streaming transpose engine. It reads rows from the
// input FIFO into the engine, then clocks the engine on its own to drain the
// remaining rows into the output FIFO, honouring output backpressure and input
// underflow. The engine and FIFOs live outside this block.
module transpose_stream_ctrl
    import transpose_stream_ctrl_pkg::*;
#(
    parameter int BLOCK_ROWS = transpose_stream_ctrl_pkg::BLOCK_ROWS,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ctx_start,
    input  logic [CNT_WIDTH-1:0] ctx_length,
    input  logic                 in_fifo_empty,
    output logic                 in_fifo_re,
    input  logic                 out_fifo_almost_full,
    output logic                 eng_start,
    output logic                 eng_clk_en,
    input  logic                 eng_start_next_stage,
    output logic                 out_fifo_we,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] rows_in,
    output logic [CNT_WIDTH-1:0] rows_out
);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [CNT_WIDTH-1:0] rows_in_q, rows_in_d;
    logic [CNT_WIDTH-1:0] rows_out_q, rows_out_d;
    logic                 err_q, err_d;
    logic                 eng_start_q;
    logic                 len_is_zero;
    logic                 len_is_block;

    assign len_is_zero  = (ctx_length == '0);
    assign len_is_block = ((ctx_length % CNT_WIDTH'(BLOCK_ROWS)) == '0);

    // Reads stop once the job's row count is in, and whenever the output side
    // is near full so the engine never produces into a full FIFO.
    assign in_fifo_re  = (state_q == STREAM) & ~in_fifo_empty & ~out_fifo_almost_full
                       & (rows_in_q != len_q);

    // A row already read always gets its engine beat; flush beats wait on
    // output space. An empty input FIFO therefore freezes the engine.
    assign eng_clk_en  = eng_start_q | ((state_q == FLUSH) & ~out_fifo_almost_full);
    assign out_fifo_we = eng_start_next_stage & eng_clk_en;

    assign eng_start = eng_start_q;
    assign busy      = (state_q == STREAM) | (state_q == FLUSH);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign rows_in   = rows_in_q;
    assign rows_out  = rows_out_q;

    // Next-state, counter and length/error bookkeeping.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        err_d      = err_q;
        rows_in_d  = rows_in_q;
        rows_out_d = rows_out_q;

        if (in_fifo_re) begin
            rows_in_d = rows_in_q + CNT_WIDTH'(1);
        end
        if (out_fifo_we) begin
            rows_out_d = rows_out_q + CNT_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (ctx_start) begin
                    len_d      = ctx_length;
                    rows_in_d  = '0;
                    rows_out_d = '0;
                    // Zero length is a legal empty job; partial blocks are not.
                    err_d      = ~len_is_zero & ~len_is_block;
                    state_d    = (len_is_zero | ~len_is_block) ? DONE : STREAM;
                end
            end
            STREAM: begin
                // Leave only after the final read has had its engine beat.
                if ((rows_in_q == len_q) && !eng_start_q) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (rows_out_q == len_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job length, counters, sticky error and the registered engine start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q       <= '0;
            rows_in_q   <= '0;
            rows_out_q  <= '0;
            err_q       <= 1'b0;
            eng_start_q <= 1'b0;
        end else begin
            len_q       <= len_d;
            rows_in_q   <= rows_in_d;
            rows_out_q  <= rows_out_d;
            err_q       <= err_d;
            eng_start_q <= in_fifo_re;
        end
    end

endmodule

// File: tb/tb_transpose_stream_ctrl.sv
// Directed bench for transpose_stream_ctrl. A delay-line engine model stands
// in for the transpose engine; per-job expectations go into a scoreboard queue
// at ctx_start and are compared when the DUT pulses done.
`timescale 1ns/1ps
module tb_transpose_stream_ctrl;
    import transpose_stream_ctrl_pkg::*;

    localparam int CW      = 32;
    localparam int ENG_LAT = 16;

    typedef struct {
        logic          err;
        logic [CW-1:0] rows_in;
        logic [CW-1:0] rows_out;
        int unsigned   reads;
        int unsigned   writes;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ctx_start = 1'b0;
    logic [CW-1:0] ctx_length = '0;
    logic          in_fifo_empty = 1'b0;
    logic          out_fifo_almost_full = 1'b0;
    logic          in_fifo_re, eng_start, eng_clk_en, eng_start_next_stage;
    logic          out_fifo_we, busy, done, err;
    logic [CW-1:0] rows_in, rows_out;
    logic [ENG_LAT-1:0] eng_pipe;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    // per-job activity, restarted by an accepted ctx_start
    int unsigned j_cyc = 0, j_re = 0, j_we = 0, j_done = 0, j_lat = 0;
    int unsigned j_re_first = 0, j_re_last = 0, done_total = 0;

    transpose_stream_ctrl #(.BLOCK_ROWS(BLOCK_ROWS), .CNT_WIDTH(CW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .ctx_start            (ctx_start),
        .ctx_length           (ctx_length),
        .in_fifo_empty        (in_fifo_empty),
        .in_fifo_re           (in_fifo_re),
        .out_fifo_almost_full (out_fifo_almost_full),
        .eng_start            (eng_start),
        .eng_clk_en           (eng_clk_en),
        .eng_start_next_stage (eng_start_next_stage),
        .out_fifo_we          (out_fifo_we),
        .busy                 (busy),
        .done                 (done),
        .err                  (err),
        .rows_in              (rows_in),
        .rows_out             (rows_out)
    );

    always #5 clk = ~clk;

    // Engine stand-in: each started row emerges ENG_LAT enabled clocks later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) eng_pipe <= '0;
        else if (eng_clk_en) eng_pipe <= {eng_pipe[ENG_LAT-2:0], eng_start};
    end
    assign eng_start_next_stage = eng_pipe[ENG_LAT-1];

    // Activity monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (ctx_start && !busy && !done) begin
            j_cyc <= 0; j_re <= 0; j_we <= 0; j_done <= 0; j_lat <= 0;
            j_re_first <= 0; j_re_last <= 0;
        end else begin
            j_cyc <= j_cyc + 1;
            if (in_fifo_re) begin
                if (j_re == 0) j_re_first <= j_cyc + 1;
                j_re_last <= j_cyc + 1;
                j_re      <= j_re + 1;
            end
            if (out_fifo_we) j_we <= j_we + 1;
            if (done) begin
                j_done <= j_done + 1;
                j_lat  <= j_cyc + 1;
            end
        end
        if (done) done_total <= done_total + 1;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Sample point: just after the falling edge (monitor updates have landed).
    task automatic tick();
        @(negedge clk); #1;
    endtask

    // Drive point: just after the rising edge.
    task automatic at_pos();
        @(posedge clk); #1;
    endtask

    task automatic push_job(input logic [CW-1:0] len);
        exp_t e;
        logic ok;
        ok         = (len != 0) && (len % BLOCK_ROWS == 0);
        e.err      = (len != 0) && !ok;
        e.rows_in  = ok ? len : '0;
        e.rows_out = ok ? len : '0;
        e.reads    = ok ? len : 0;
        e.writes   = ok ? len : 0;
        sb.push_back(e);
        at_pos();
        ctx_start  = 1'b1;
        ctx_length = len;
        at_pos();
        ctx_start  = 1'b0;
    endtask

    task automatic finish_job(input string tag);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        if (!seen) chk({tag, "_done_timeout"}, 64'(0), 64'(1));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(0), 64'(1));
        end else begin
            e = sb.pop_front();
            if (seen) begin
                chk({tag, "_err"},      64'(err),      64'(e.err));
                chk({tag, "_rows_in"},  64'(rows_in),  64'(e.rows_in));
                chk({tag, "_rows_out"}, 64'(rows_out), 64'(e.rows_out));
                chk({tag, "_reads"},    64'(j_re),     64'(e.reads));
                chk({tag, "_writes"},   64'(j_we),     64'(e.writes));
                tick();
                chk({tag, "_done_width"}, 64'(j_done), 64'(1));
                chk({tag, "_busy_after"}, 64'(busy),   64'(0));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bad_re, bad_cen, bad_we, guard;
        logic [CW-1:0] ro_snap;
        int unsigned dt_snap;

        // reset state
        #3;
        chk("rst_ctrl", 64'({busy, done, err, eng_start, in_fifo_re, eng_clk_en, out_fifo_we}), 64'(0));
        chk("rst_rows_in",  64'(rows_in),  64'(0));
        chk("rst_rows_out", 64'(rows_out), 64'(0));
        #20;
        @(negedge clk); #1 reset = 1'b1;
        tick();

        // 128 rows, no stalls; a stray ctx_start mid-job must be ignored
        push_job(128);
        guard = 0;
        while (rows_in < 10 && guard < 500) begin at_pos(); guard++; end
        ctx_start  = 1'b1;
        ctx_length = 100;
        at_pos();
        ctx_start  = 1'b0;
        finish_job("len128");
        chk("len128_consecutive", 64'(j_re_last - j_re_first + 1), 64'(128));

        // 64 rows with 10 cycles of output backpressure during the flush
        push_job(64);
        guard = 0;
        while (rows_in != 64 && guard < 500) begin at_pos(); guard++; end
        chk("bp_reached_len", 64'(rows_in), 64'(64));
        repeat (3) at_pos();
        out_fifo_almost_full = 1'b1;
        ro_snap = rows_out;
        bad_cen = 0; bad_we = 0;
        repeat (10) begin
            tick();
            if (eng_clk_en)  bad_cen++;
            if (out_fifo_we) bad_we++;
        end
        chk("bp_busy_in_flush", 64'(busy),    64'(1));
        chk("bp_clk_en_low",    64'(bad_cen), 64'(0));
        chk("bp_we_low",        64'(bad_we),  64'(0));
        chk("bp_rows_frozen",   64'(rows_out), 64'(ro_snap));
        at_pos();
        out_fifo_almost_full = 1'b0;
        finish_job("bp64");

        // partial-block length: immediate error completion
        push_job(100);
        finish_job("len100");
        chk("len100_done_lat", 64'(j_lat), 64'(1));
        repeat (3) tick();
        chk("len100_err_sticky", 64'(err), 64'(1));

        // zero length: empty job, error cleared by the new start
        push_job(0);
        finish_job("len0");
        chk("len0_done_lat", 64'(j_lat), 64'(1));

        // input underflow after row 30; the in-flight beat finishes first
        push_job(64);
        guard = 0;
        while (rows_in != 30 && guard < 500) begin at_pos(); guard++; end
        in_fifo_empty = 1'b1;
        tick();
        chk("stall_drain_re", 64'(in_fifo_re), 64'(0));
        bad_re = 0; bad_cen = 0;
        repeat (5) begin
            tick();
            if (in_fifo_re) bad_re++;
            if (eng_clk_en) bad_cen++;
        end
        chk("stall_re_low",     64'(bad_re),  64'(0));
        chk("stall_clk_en_low", 64'(bad_cen), 64'(0));
        chk("stall_rows_in",    64'(rows_in), 64'(30));
        chk("stall_busy",       64'(busy),    64'(1));
        at_pos();
        in_fifo_empty = 1'b0;
        finish_job("stall64");

        // reset mid-job abandons it without a done pulse
        sb.push_back('{err: 1'b0, rows_in: '0, rows_out: '0, reads: 0, writes: 0});
        void'(sb.pop_back());
        at_pos();
        ctx_start  = 1'b1;
        ctx_length = 64;
        at_pos();
        ctx_start  = 1'b0;
        guard = 0;
        while (rows_in != 40 && guard < 500) begin at_pos(); guard++; end
        dt_snap = done_total;
        #2 reset = 1'b0;
        #1;
        chk("midrst_ctrl", 64'({busy, done, err, eng_start, in_fifo_re, eng_clk_en, out_fifo_we}), 64'(0));
        chk("midrst_rows_in",  64'(rows_in),  64'(0));
        chk("midrst_rows_out", 64'(rows_out), 64'(0));
        repeat (2) tick();
        reset = 1'b1;
        repeat (5) tick();
        chk("midrst_no_done", 64'(done_total), 64'(dt_snap));
        push_job(64);
        finish_job("after_rst64");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
